// File: rtl/decryption_pkg.sv
// Shared encodings for the decryption scheduler: algorithm codes, FSM states
// and the default register map of the decryption datapath.
package decryption_pkg;

   localparam logic [1:0] ALG_CAESAR  = 2'd0;
   localparam logic [1:0] ALG_SCYTALE = 2'd1;
   localparam logic [1:0] ALG_ZIGZAG  = 2'd2;
   localparam logic [1:0] ALG_INVALID = 2'd3;

   localparam logic [7:0] DEF_SEL_ADDR         = 8'h00;
   localparam logic [7:0] DEF_CAESAR_KEY_ADDR  = 8'h10;
   localparam logic [7:0] DEF_SCYTALE_KEY_ADDR = 8'h12;
   localparam logic [7:0] DEF_ZIGZAG_KEY_ADDR  = 8'h14;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_SEL,
      ST_WAIT_SEL,
      ST_WR_KEY,
      ST_WAIT_KEY,
      ST_STREAM,
      ST_DRAIN,
      ST_FINISH,
      ST_FAIL
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the requester after the last
// completed grant; the pointer only moves when the scheduler retires a job.
module rr_arbiter #(
   parameter  int N_REQ = 2,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_i,
   input  logic             upd_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   output logic             gnt_vld_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   int               cand;

   // Scan from the highest offset down so the nearest requester wins last.
   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      cand      = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = (int'(ptr_q) + i) % N_REQ;
         if (req_i[cand]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (upd_i) begin
         ptr_d = (upd_idx_i == IDX_W'(N_REQ - 1)) ? '0 : upd_idx_i + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/decryption_scheduler.sv
// Shares the decryption datapath between N_REQ sources: programs select and
// key registers for the granted job, streams its words, then reports done/err.
module decryption_scheduler
   import decryption_pkg::*;
#(
   parameter int                     N_REQ            = 2,
   parameter int                     MST_DWIDTH       = 32,
   parameter int                     LEN_W            = 8,
   parameter int                     addr_witdth      = 8,
   parameter int                     reg_width        = 16,
   parameter logic [addr_witdth-1:0] SEL_ADDR         = addr_witdth'(DEF_SEL_ADDR),
   parameter logic [addr_witdth-1:0] CAESAR_KEY_ADDR  = addr_witdth'(DEF_CAESAR_KEY_ADDR),
   parameter logic [addr_witdth-1:0] SCYTALE_KEY_ADDR = addr_witdth'(DEF_SCYTALE_KEY_ADDR),
   parameter logic [addr_witdth-1:0] ZIGZAG_KEY_ADDR  = addr_witdth'(DEF_ZIGZAG_KEY_ADDR)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_i,
   input  logic [2*N_REQ-1:0]          alg_i,
   input  logic [reg_width*N_REQ-1:0]  key_i,
   input  logic [LEN_W*N_REQ-1:0]      len_i,
   input  logic [MST_DWIDTH*N_REQ-1:0] src_data_i,
   input  logic [N_REQ-1:0]            src_valid_i,
   output logic [N_REQ-1:0]            src_ready_o,
   output logic [N_REQ-1:0]            done_o,
   output logic [N_REQ-1:0]            err_o,
   output logic [MST_DWIDTH-1:0]       dec_data_o,
   output logic                        dec_valid_o,
   input  logic                        dec_busy_i,
   output logic [addr_witdth-1:0]      reg_addr_o,
   output logic                        reg_write_o,
   output logic                        reg_read_o,
   output logic [reg_width-1:0]        reg_wdata_o,
   input  logic                        reg_done_i,
   input  logic                        reg_error_i
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] g_q, g_d;
   logic [1:0]       alg_q, alg_d;
   logic [reg_width-1:0] key_q, key_d;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic             drain_q, drain_d;
   logic             gnt_vld, arb_upd, xfer;
   logic [IDX_W-1:0] gnt_idx;

   function automatic logic [addr_witdth-1:0] key_addr(input logic [1:0] alg);
      logic [addr_witdth-1:0] a;
      case (alg)
         ALG_SCYTALE: a = SCYTALE_KEY_ADDR;
         ALG_ZIGZAG:  a = ZIGZAG_KEY_ADDR;
         default:     a = CAESAR_KEY_ADDR;
      endcase
      return a;
   endfunction

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_i),
      .upd_i     (arb_upd),
      .upd_idx_i (g_q),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   assign xfer       = (state_q == ST_STREAM) && src_valid_i[g_q] && !dec_busy_i;
   assign reg_read_o = 1'b0;

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      alg_d   = alg_q;
      key_d   = key_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      arb_upd = 1'b0;
      case (state_q)
         ST_IDLE: if (gnt_vld) begin
            g_d     = gnt_idx;
            alg_d   = alg_i[int'(gnt_idx)*2 +: 2];
            key_d   = key_i[int'(gnt_idx)*reg_width +: reg_width];
            len_d   = len_i[int'(gnt_idx)*LEN_W +: LEN_W];
            cnt_d   = '0;
            state_d = (alg_i[int'(gnt_idx)*2 +: 2] == ALG_INVALID) ? ST_FAIL : ST_WR_SEL;
         end
         ST_WR_SEL: state_d = ST_WAIT_SEL;
         ST_WAIT_SEL: begin
            if (reg_error_i)     state_d = ST_FAIL;
            else if (reg_done_i) state_d = ST_WR_KEY;
         end
         ST_WR_KEY: state_d = ST_WAIT_KEY;
         ST_WAIT_KEY: begin
            if (reg_error_i)     state_d = ST_FAIL;
            else if (reg_done_i) state_d = (len_q != '0) ? ST_STREAM : ST_FINISH;
         end
         ST_STREAM: if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
               state_d = ST_DRAIN;
               drain_d = 1'b0;
            end
         end
         // drain_q marks that the mandatory second drain cycle has been reached.
         ST_DRAIN: begin
            if (drain_q && !dec_busy_i) state_d = ST_FINISH;
            drain_d = 1'b1;
         end
         ST_FINISH, ST_FAIL: begin
            arb_upd = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         g_q     <= '0;
         cnt_q   <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end
   end

   always_ff @(posedge clk) begin
      alg_q <= alg_d;
      key_q <= key_d;
      len_q <= len_d;
   end

   // Outputs decode only the registered state, so reset clears them next cycle.
   always_comb begin
      reg_write_o = 1'b0;
      reg_addr_o  = '0;
      reg_wdata_o = '0;
      src_ready_o = '0;
      dec_valid_o = 1'b0;
      dec_data_o  = '0;
      done_o      = '0;
      err_o       = '0;
      case (state_q)
         ST_WR_SEL: begin
            reg_write_o = 1'b1;
            reg_addr_o  = SEL_ADDR;
            reg_wdata_o = reg_width'(alg_q);
         end
         ST_WR_KEY: begin
            reg_write_o = 1'b1;
            reg_addr_o  = key_addr(alg_q);
            reg_wdata_o = key_q;
         end
         ST_STREAM: begin
            src_ready_o[g_q] = !dec_busy_i;
            dec_valid_o      = xfer;
            if (xfer) dec_data_o = src_data_i[int'(g_q)*MST_DWIDTH +: MST_DWIDTH];
         end
         ST_FINISH: done_o[g_q] = 1'b1;
         ST_FAIL:   err_o[g_q]  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_decryption_scheduler.sv
// Randomized scoreboard bench for decryption_scheduler with a job-level
// round-robin reference model.
module tb_decryption_scheduler;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int AW = 8;
   localparam int RW = 16;

   typedef struct { logic [AW-1:0] addr; logic [RW-1:0] data; } rw_t;
   typedef struct { logic [DW-1:0] data; int r; bit last; } wd_t;
   typedef struct { int r; bit err; } cp_t;
   typedef struct { logic [1:0] alg; logic [RW-1:0] key; logic [LW-1:0] len; logic [31:0] salt; } job_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0]    req_i = '0, src_valid_i = '0, src_ready_o, done_o, err_o;
   logic [2*N-1:0]  alg_i = '0;
   logic [RW*N-1:0] key_i = '0;
   logic [LW*N-1:0] len_i = '0;
   logic [DW*N-1:0] src_data_i = '0;
   logic [DW-1:0]   dec_data_o;
   logic            dec_valid_o, dec_busy_i = 1'b0;
   logic [AW-1:0]   reg_addr_o;
   logic            reg_write_o, reg_read_o;
   logic [RW-1:0]   reg_wdata_o;
   logic            reg_done_i = 1'b0, reg_error_i = 1'b0;

   decryption_scheduler #(.N_REQ(N), .MST_DWIDTH(DW), .LEN_W(LW), .addr_witdth(AW), .reg_width(RW)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .alg_i(alg_i), .key_i(key_i), .len_i(len_i),
      .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
      .done_o(done_o), .err_o(err_o), .dec_data_o(dec_data_o), .dec_valid_o(dec_valid_o),
      .dec_busy_i(dec_busy_i), .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o),
      .reg_read_o(reg_read_o), .reg_wdata_o(reg_wdata_o), .reg_done_i(reg_done_i),
      .reg_error_i(reg_error_i)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   rw_t exp_rw[$];
   wd_t exp_wd[$];
   cp_t exp_cp[$];
   job_t req_jobs[N][$];
   job_t stage[N][$];
   int  idx[N];
   int  mdl_ptr = 0;
   bit  fast = 1'b1, sel_err_en = 1'b0, key_err_en = 1'b0, mon_en = 1'b1;
   int  busy_mode = 0, burst_left = 0, hs_count = 0, words_cnt = 0;
   bit  burst_done = 1'b0;
   bit  resp_pend = 1'b0, resp_err = 1'b0;
   int  resp_wait = 0;
   int  mon_drain = -1;
   bit  exp_done = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] wordf(input int r, input int k, input logic [31:0] salt);
      return salt ^ (32'(k) * 32'h01000193) ^ (32'(r) << 30);
   endfunction

   function automatic logic [AW-1:0] keyaddr(input logic [1:0] alg);
      return (alg == 2'd1) ? 8'h12 : (alg == 2'd2) ? 8'h14 : 8'h10;
   endfunction

   // Sources, register responder and busy generator; inputs change on negedge.
   initial begin
      job_t j;
      forever begin
         @(negedge clk);
         for (int r = 0; r < N; r++) begin
            if ((done_o[r] || err_o[r]) && req_jobs[r].size() > 0) begin
               void'(req_jobs[r].pop_front());
               idx[r] = 0;
            end
            if (req_jobs[r].size() > 0) begin
               j = req_jobs[r][0];
               req_i[r] = 1'b1;
               alg_i[r*2 +: 2] = j.alg;
               key_i[r*RW +: RW] = j.key;
               len_i[r*LW +: LW] = j.len;
               src_data_i[r*DW +: DW] = wordf(r, idx[r], j.salt);
            end else begin
               req_i[r] = 1'b0;
               src_data_i[r*DW +: DW] = $urandom;
            end
            src_valid_i[r] = fast ? 1'b1 : ($urandom % 4 != 0);
         end
         if (busy_mode == 2) begin
            if (!burst_done && hs_count == 3) begin
               burst_left = 3;
               burst_done = 1'b1;
            end
         end else if (busy_mode == 1 && burst_left == 0 && $urandom % 5 == 0) begin
            burst_left = 1 + $urandom % 4;
         end
         dec_busy_i = (burst_left > 0);
         if (burst_left > 0) burst_left--;
         reg_done_i = 1'b0;
         reg_error_i = 1'b0;
         if (resp_pend) begin
            if (resp_wait == 0) begin
               resp_pend = 1'b0;
               if (resp_err) begin
                  reg_error_i = 1'b1;
                  reg_done_i = fast ? 1'b0 : 1'($urandom % 2);
               end else begin
                  reg_done_i = 1'b1;
               end
            end else begin
               resp_wait--;
            end
         end
         if (reg_write_o) begin
            resp_pend = 1'b1;
            resp_wait = fast ? 0 : int'($urandom % 3);
            resp_err = (reg_addr_o == 8'h00) ? (sel_err_en && reg_wdata_o == 16'd2)
                                             : (key_err_en && reg_wdata_o[15]);
            if (!fast && $urandom % 3 == 0) reg_done_i = 1'b1;
         end
         #1;
         for (int r = 0; r < N; r++) begin
            if (src_ready_o[r] && src_valid_i[r]) begin
               idx[r]++;
               hs_count++;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial begin
      rw_t e; wd_t w; cp_t c;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            chk(reg_read_o == 1'b0, "reg_read_tied", 64'(reg_read_o), 0);
            if (reg_write_o) begin
               if (exp_rw.size() == 0) chk(1'b0, "reg_write_unexpected", {reg_addr_o, reg_wdata_o}, 0);
               else begin
                  e = exp_rw.pop_front();
                  chk(reg_addr_o == e.addr && reg_wdata_o == e.data, "reg_write",
                      {reg_addr_o, reg_wdata_o}, {e.addr, e.data});
               end
            end
            if (dec_busy_i) chk(!dec_valid_o && src_ready_o == '0, "busy_blocks", {src_ready_o, dec_valid_o}, 0);
            if (exp_done) chk(done_o != '0, "drain_exit", 64'(done_o), 1);
            exp_done = 1'b0;
            if (mon_drain >= 0) begin
               mon_drain++;
               if (mon_drain >= 2 && !dec_busy_i) begin
                  exp_done = 1'b1;
                  mon_drain = -1;
               end
            end
            if (dec_valid_o) begin
               words_cnt++;
               if (exp_wd.size() == 0) chk(1'b0, "word_unexpected", 64'(dec_data_o), 0);
               else begin
                  w = exp_wd.pop_front();
                  chk(dec_data_o == w.data, "dec_data", 64'(dec_data_o), 64'(w.data));
                  chk(src_ready_o == N'(1 << w.r), "src_ready", 64'(src_ready_o), 64'(1 << w.r));
                  if (w.last) mon_drain = 0;
               end
            end else begin
               chk(dec_data_o == '0, "data_zero_idle", 64'(dec_data_o), 0);
            end
            if ((done_o | err_o) != '0) begin
               chk($onehot(done_o | err_o), "pulse_onehot", {done_o, err_o}, 0);
               if (done_o != '0) chk(mon_drain < 0, "early_done", 64'(done_o), 0);
               if (exp_cp.size() == 0) chk(1'b0, "pulse_unexpected", {done_o, err_o}, 0);
               else begin
                  c = exp_cp.pop_front();
                  chk(done_o == (c.err ? N'(0) : N'(1 << c.r)) && err_o == (c.err ? N'(1 << c.r) : N'(0)),
                      "completion", {done_o, err_o},
                      c.err ? 64'(1 << c.r) : 64'((1 << c.r) << N));
               end
            end
         end
      end
   end

   task automatic add_job(input int r, input logic [1:0] alg, input logic [RW-1:0] key,
                          input logic [LW-1:0] len);
      job_t j;
      j.alg = alg; j.key = key; j.len = len; j.salt = $urandom;
      stage[r].push_back(j);
   endtask

   task automatic push_expect(input int r, input job_t j);
      rw_t e; wd_t w; cp_t c;
      c.r = r; c.err = 1'b1;
      if (j.alg != 2'd3) begin
         e.addr = 8'h00; e.data = 16'(j.alg); exp_rw.push_back(e);
         if (!(sel_err_en && j.alg == 2'd2)) begin
            e.addr = keyaddr(j.alg); e.data = j.key; exp_rw.push_back(e);
            if (!(key_err_en && j.key[15])) begin
               for (int k = 0; k < int'(j.len); k++) begin
                  w.data = wordf(r, k, j.salt); w.r = r; w.last = (k == int'(j.len) - 1);
                  exp_wd.push_back(w);
               end
               c.err = 1'b0;
            end
         end
      end
      exp_cp.push_back(c);
   endtask

   // Every staged job is held until served, so grants follow RR over pending jobs.
   task automatic launch();
      int pos[N]; int total, served;
      @(negedge clk); #3;
      total = 0; served = 0;
      for (int r = 0; r < N; r++) begin pos[r] = 0; total += stage[r].size(); end
      while (served < total) begin
         for (int i = 0; i < N; i++) begin
            int r = (mdl_ptr + i) % N;
            if (pos[r] < stage[r].size()) begin
               push_expect(r, stage[r][pos[r]]);
               pos[r]++; served++;
               mdl_ptr = (r + 1) % N;
               break;
            end
         end
      end
      hs_count = 0; burst_done = 1'b0;
      for (int r = 0; r < N; r++) begin
         req_jobs[r] = stage[r];
         idx[r] = 0;
         stage[r].delete();
      end
   endtask

   task automatic wait_phase();
      bit fin = 1'b0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         @(negedge clk); #3;
         fin = (req_jobs[0].size() == 0 && req_jobs[1].size() == 0 && exp_cp.size() == 0);
      end
      chk(fin, "phase_timeout", 64'(exp_cp.size()), 0);
      chk(exp_rw.size() == 0 && exp_wd.size() == 0, "leftover_expect",
          64'(exp_rw.size() + exp_wd.size()), 0);
      if (!fin) begin
         for (int r = 0; r < N; r++) req_jobs[r].delete();
         exp_rw.delete(); exp_wd.delete(); exp_cp.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic timed(output int n);
      launch();
      @(negedge clk); #3;
      n = 0;
      while (n < 400) begin
         @(negedge clk); #3;
         n++;
         if ((done_o | err_o) != '0) break;
      end
      wait_phase();
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      #3;
      chk({done_o, err_o, src_ready_o, dec_valid_o, reg_write_o, reg_read_o, reg_addr_o, reg_wdata_o} == '0,
          "reset_ctrl_outputs", {done_o, err_o, src_ready_o, reg_addr_o, reg_wdata_o}, 0);
      chk(dec_data_o == '0, "reset_data_output", 64'(dec_data_o), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      add_job(0, 2'd0, 16'h0003, 8'd4); timed(n);
      chk(n == 11, "latency_len4", 64'(n), 11);
      add_job(1, 2'd1, 16'h1234, 8'd0); timed(n);
      chk(n == 5, "latency_len0", 64'(n), 5);
      add_job(0, 2'd3, 16'h5555, 8'd3); timed(n);
      chk(n == 1, "latency_invalid_alg", 64'(n), 1);
      for (int r = 0; r < N; r++) begin
         add_job(r, 2'd0, 16'h0101, 8'd2); add_job(r, 2'd1, 16'h0202, 8'd2);
      end
      launch(); wait_phase();

      key_err_en = 1'b1;
      add_job(1, 2'd2, 16'h8001, 8'd3); launch(); wait_phase();
      key_err_en = 1'b0; sel_err_en = 1'b1;
      add_job(0, 2'd2, 16'h0007, 8'd3); launch(); wait_phase();
      sel_err_en = 1'b0; busy_mode = 2;
      add_job(1, 2'd0, 16'h0009, 8'd6); launch(); wait_phase();
      busy_mode = 0;
      add_job(0, 2'd1, 16'h0aaa, 8'd255); launch(); wait_phase();

      // Abort a job mid-stream and confirm a clean restart from requester 0.
      add_job(0, 2'd0, 16'h0011, 8'd6); launch();
      words_cnt = 0;
      for (int cyc = 0; cyc < 100 && words_cnt < 2; cyc++) begin @(negedge clk); #3; end
      rst = 1'b1; mon_en = 1'b0; resp_pend = 1'b0;
      req_jobs[0].delete(); exp_rw.delete(); exp_wd.delete(); exp_cp.delete();
      @(negedge clk); #3;
      chk({done_o, err_o, src_ready_o, dec_valid_o, reg_write_o, reg_addr_o, reg_wdata_o} == '0,
          "rst_abort_outputs", {done_o, err_o, src_ready_o, dec_valid_o, reg_write_o}, 0);
      chk(dec_data_o == '0, "rst_abort_data", 64'(dec_data_o), 0);
      rst = 1'b0; mdl_ptr = 0; mon_drain = -1; exp_done = 1'b0; resp_pend = 1'b0; mon_en = 1'b1;
      repeat (4) @(negedge clk);
      add_job(0, 2'd2, 16'h0022, 8'd2); add_job(1, 2'd0, 16'h0033, 8'd2);
      launch(); wait_phase();

      for (int p = 0; p < 30; p++) begin
         int mask;
         sel_err_en = ($urandom % 4 == 0);
         key_err_en = ($urandom % 4 == 0);
         fast = ($urandom % 3 == 0);
         busy_mode = int'($urandom % 2);
         mask = 1 + int'($urandom % 3);
         for (int r = 0; r < N; r++) begin
            if (mask[r]) begin
               int nj = 1 + int'($urandom % 2);
               for (int k = 0; k < nj; k++)
                  add_job(r, ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3), 16'($urandom), 8'($urandom % 9));
            end
         end
         launch(); wait_phase();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
